// File: rtl/sc_datapath.sv
// Execution datapath for the SC control FSM: GEN/FIX registers, BUS A/B muxes, ALU with active-low flags, BUSC shifter.
// Optional registered debug read port enabled by defining SC_DATAPATH_DEBUG_READ_EN.
module sc_datapath #(
    parameter int DATAWIDTH_BUS                  = 8,
    parameter int DATAWIDTH_DECODER_SELECTION    = 3,
    parameter int DATAWIDTH_MUX_SELECTION        = 3,
    parameter int DATAWIDTH_ALU_SELECTION        = 4,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter logic [DATAWIDTH_BUS-1:0] FIX0_RESET_VALUE = 8'h00,
    parameter logic [DATAWIDTH_BUS-1:0] FIX1_RESET_VALUE = 8'h01
) (
    input  logic                                      SC_DATAPATH_CLOCK_50,
    input  logic                                      SC_DATAPATH_Reset_InLow,
    input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_DecoderSelectionWrite_In,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_MUXSelectionBUSA_In,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_MUXSelectionBUSB_In,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_DATAPATH_ALUSelection_In,
    input  logic                                      SC_DATAPATH_RegSHIFTERLoad_InLow,
    input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_DATAPATH_RegSHIFTERShiftSelection_InLow,
    input  logic                                      SC_DATAPATH_FIXLoad_InLow,
    input  logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_FIX0_In,
    input  logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_FIX1_In,
    output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_BUSC_Out,
    output logic                                      SC_DATAPATH_Overflow_OutLow,
    output logic                                      SC_DATAPATH_Carry_OutLow,
    output logic                                      SC_DATAPATH_Negative_OutLow,
    output logic                                      SC_DATAPATH_Zero_OutLow
`ifdef SC_DATAPATH_DEBUG_READ_EN
    ,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_DebugSelection_In,
    output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_Debug_Out
`endif
);

    localparam int W = DATAWIDTH_BUS;

    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_PASS = 4'b0000;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_OR   = 4'b0001;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_AND  = 4'b0010;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_NOT  = 4'b0011;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_XOR  = 4'b0100;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ADD  = 4'b1000;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_SUB  = 4'b1001;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_INC  = 4'b1010;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_DEC  = 4'b1011;

    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SHIFT_RIGHT = 2'b10;

    logic [W-1:0] reg_gen [4];
    logic [W-1:0] reg_fix0;
    logic [W-1:0] reg_fix1;
    logic [W-1:0] reg_shifter;

    logic [W-1:0] mux_src [8];
    logic [W-1:0] bus_a;
    logic [W-1:0] bus_b;

    logic [W-1:0] alu_result;
    logic         alu_carry;
    logic         alu_overflow;
    logic [W:0]   add_ext;
    logic [W:0]   inc_ext;
    logic [W-1:0] sub_res;
    logic [W-1:0] dec_res;

    // Shared source table for both bus muxes; codes 110/111 read as zero.
    always_comb begin
        mux_src[0] = reg_gen[0];
        mux_src[1] = reg_gen[1];
        mux_src[2] = reg_gen[2];
        mux_src[3] = reg_gen[3];
        mux_src[4] = reg_fix0;
        mux_src[5] = reg_fix1;
        mux_src[6] = '0;
        mux_src[7] = '0;
    end

    assign bus_a = mux_src[SC_DATAPATH_MUXSelectionBUSA_In];
    assign bus_b = mux_src[SC_DATAPATH_MUXSelectionBUSB_In];

    assign add_ext = {1'b0, bus_a} + {1'b0, bus_b};
    assign inc_ext = {1'b0, bus_a} + (W+1)'(1);
    assign sub_res = bus_a - bus_b;
    assign dec_res = bus_a - W'(1);

    always_comb begin
        alu_result   = bus_a;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (SC_DATAPATH_ALUSelection_In)
            ALU_PASS: alu_result = bus_a;
            ALU_OR:   alu_result = bus_a | bus_b;
            ALU_AND:  alu_result = bus_a & bus_b;
            ALU_NOT:  alu_result = ~bus_a;
            ALU_XOR:  alu_result = bus_a ^ bus_b;
            ALU_ADD: begin
                alu_result   = add_ext[W-1:0];
                alu_carry    = add_ext[W];
                alu_overflow = (bus_a[W-1] == bus_b[W-1]) && (add_ext[W-1] != bus_a[W-1]);
            end
            ALU_SUB: begin
                alu_result   = sub_res;
                alu_carry    = (bus_a < bus_b);
                alu_overflow = (bus_a[W-1] != bus_b[W-1]) && (sub_res[W-1] != bus_a[W-1]);
            end
            ALU_INC: begin
                alu_result   = inc_ext[W-1:0];
                alu_carry    = inc_ext[W];
                alu_overflow = !bus_a[W-1] && inc_ext[W-1];
            end
            ALU_DEC: begin
                alu_result   = dec_res;
                alu_carry    = (bus_a == '0);
                alu_overflow = bus_a[W-1] && !dec_res[W-1];
            end
            default: alu_result = bus_a;
        endcase
    end

    // Flags are combinational so the control FSM can branch in the same cycle.
    assign SC_DATAPATH_Zero_OutLow     = ~(alu_result == '0);
    assign SC_DATAPATH_Negative_OutLow = ~alu_result[W-1];
    assign SC_DATAPATH_Carry_OutLow    = ~alu_carry;
    assign SC_DATAPATH_Overflow_OutLow = ~alu_overflow;

    assign SC_DATAPATH_BUSC_Out = reg_shifter;

    // GEN writes sample reg_shifter before this edge's load, so they see the old BUSC.
    always_ff @(posedge SC_DATAPATH_CLOCK_50) begin
        if (!SC_DATAPATH_Reset_InLow) begin
            for (int i = 0; i < 4; i++) begin
                reg_gen[i] <= '0;
            end
            reg_fix0    <= FIX0_RESET_VALUE;
            reg_fix1    <= FIX1_RESET_VALUE;
            reg_shifter <= '0;
        end else begin
            if (!SC_DATAPATH_RegSHIFTERLoad_InLow) begin
                reg_shifter <= alu_result;
            end else if (SC_DATAPATH_RegSHIFTERShiftSelection_InLow == SHIFT_LEFT) begin
                reg_shifter <= {reg_shifter[W-2:0], 1'b0};
            end else if (SC_DATAPATH_RegSHIFTERShiftSelection_InLow == SHIFT_RIGHT) begin
                reg_shifter <= {1'b0, reg_shifter[W-1:1]};
            end

            if (SC_DATAPATH_DecoderSelectionWrite_In[DATAWIDTH_DECODER_SELECTION-1:2] == '0) begin
                reg_gen[SC_DATAPATH_DecoderSelectionWrite_In[1:0]] <= reg_shifter;
            end

            if (!SC_DATAPATH_FIXLoad_InLow) begin
                reg_fix0 <= SC_DATAPATH_FIX0_In;
                reg_fix1 <= SC_DATAPATH_FIX1_In;
            end
        end
    end

`ifdef SC_DATAPATH_DEBUG_READ_EN
    always_ff @(posedge SC_DATAPATH_CLOCK_50) begin
        if (!SC_DATAPATH_Reset_InLow) begin
            SC_DATAPATH_Debug_Out <= '0;
        end else begin
            SC_DATAPATH_Debug_Out <= mux_src[SC_DATAPATH_DebugSelection_In];
        end
    end
`endif

endmodule

// File: tb/tb_sc_datapath.sv
// Directed bench for sc_datapath: table-driven ALU/flag vectors plus hand-written multi-cycle sequences.
module tb_sc_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] dec_sel;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic [3:0] alu_op;
    logic       load_n;
    logic [1:0] shift_sel;
    logic       fix_load_n;
    logic [7:0] fix0_in;
    logic [7:0] fix1_in;
    logic [7:0] busc;
    logic       ov_n, c_n, n_n, z_n;
`ifdef SC_DATAPATH_DEBUG_READ_EN
    logic [2:0] dbg_sel;
    logic [7:0] dbg_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    sc_datapath dut (
        .SC_DATAPATH_CLOCK_50                       (clk),
        .SC_DATAPATH_Reset_InLow                    (rst_n),
        .SC_DATAPATH_DecoderSelectionWrite_In       (dec_sel),
        .SC_DATAPATH_MUXSelectionBUSA_In            (sel_a),
        .SC_DATAPATH_MUXSelectionBUSB_In            (sel_b),
        .SC_DATAPATH_ALUSelection_In                (alu_op),
        .SC_DATAPATH_RegSHIFTERLoad_InLow           (load_n),
        .SC_DATAPATH_RegSHIFTERShiftSelection_InLow (shift_sel),
        .SC_DATAPATH_FIXLoad_InLow                  (fix_load_n),
        .SC_DATAPATH_FIX0_In                        (fix0_in),
        .SC_DATAPATH_FIX1_In                        (fix1_in),
        .SC_DATAPATH_BUSC_Out                       (busc),
        .SC_DATAPATH_Overflow_OutLow                (ov_n),
        .SC_DATAPATH_Carry_OutLow                   (c_n),
        .SC_DATAPATH_Negative_OutLow                (n_n),
        .SC_DATAPATH_Zero_OutLow                    (z_n)
`ifdef SC_DATAPATH_DEBUG_READ_EN
        ,
        .SC_DATAPATH_DebugSelection_In              (dbg_sel),
        .SC_DATAPATH_Debug_Out                      (dbg_out)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] res;
        logic [3:0] flg;  // {ov_n, c_n, n_n, z_n}
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n      = 1'b1;
        dec_sel    = 3'b111;
        sel_a      = 3'b110;
        sel_b      = 3'b110;
        alu_op     = 4'b0000;
        load_n     = 1'b1;
        shift_sel  = 2'b00;
        fix_load_n = 1'b1;
`ifdef SC_DATAPATH_DEBUG_READ_EN
        dbg_sel    = 3'b110;
`endif
    endtask

    task automatic load_fix(input logic [7:0] f0, input logic [7:0] f1);
        idle();
        fix0_in    = f0;
        fix1_in    = f1;
        fix_load_n = 1'b0;
        tick();
        idle();
    endtask

    // Copies a register through the ALU pass op into BUSC and checks it.
    task automatic read_reg(input logic [2:0] sel, input logic [7:0] exp, input string name);
        idle();
        sel_a  = sel;
        load_n = 1'b0;
        tick();
        idle();
        check(name, busc, exp);
    endtask

    function automatic logic [7:0] flags();
        return {4'b0000, ov_n, c_n, n_n, z_n};
    endfunction

    // ABS of FIX0 into GEN3; stop_early leaves it after the first GEN3 write.
    task automatic abs_seq(input logic stop_early);
        load_fix(8'hF6, 8'h01);
        sel_a = 3'b100;
        #1;
        check("abs_neg_flag", {7'd0, n_n}, 8'h00);
        alu_op = 4'b0011;
        load_n = 1'b0;
        tick();
        idle();
        check("abs_not", busc, 8'h09);
        dec_sel = 3'b011;
        tick();
        idle();
        if (!stop_early) begin
            sel_a  = 3'b011;
            alu_op = 4'b1010;
            load_n = 1'b0;
            tick();
            idle();
            check("abs_inc", busc, 8'h0A);
            dec_sel = 3'b011;
            tick();
            idle();
            sel_a = 3'b011;
            #1;
            check("abs_zero_flag", {7'd0, z_n}, 8'h01);
            read_reg(3'b011, 8'h0A, "abs_gen3");
        end
    endtask

    initial begin
        vecs[0]  = '{8'h7F, 8'h01, 4'b1000, 8'h80, 4'b0101};
        vecs[1]  = '{8'hFF, 8'h01, 4'b1000, 8'h00, 4'b1010};
        vecs[2]  = '{8'h00, 8'h01, 4'b1011, 8'hFF, 4'b1001};
        vecs[3]  = '{8'h05, 8'h05, 4'b1001, 8'h00, 4'b1110};
        vecs[4]  = '{8'h03, 8'h05, 4'b1001, 8'hFE, 4'b1001};
        vecs[5]  = '{8'h80, 8'h01, 4'b1001, 8'h7F, 4'b0111};
        vecs[6]  = '{8'h7F, 8'h33, 4'b1010, 8'h80, 4'b0101};
        vecs[7]  = '{8'hFF, 8'h33, 4'b1010, 8'h00, 4'b1010};
        vecs[8]  = '{8'h80, 8'h33, 4'b1011, 8'h7F, 4'b0111};
        vecs[9]  = '{8'hF0, 8'h0F, 4'b0001, 8'hFF, 4'b1101};
        vecs[10] = '{8'hF0, 8'h0F, 4'b0010, 8'h00, 4'b1110};
        vecs[11] = '{8'h3C, 8'h0F, 4'b0011, 8'hC3, 4'b1101};
        vecs[12] = '{8'hAA, 8'hFF, 4'b0100, 8'h55, 4'b1111};
        vecs[13] = '{8'h81, 8'hFF, 4'b0110, 8'h81, 4'b1101};
        vecs[14] = '{8'h81, 8'hFF, 4'b1111, 8'h81, 4'b1101};
        vecs[15] = '{8'hFF, 8'hFF, 4'b1000, 8'hFE, 4'b1001};
        vecs[16] = '{8'h80, 8'h7F, 4'b0000, 8'h80, 4'b1101};

        fix0_in = 8'h00;
        fix1_in = 8'h00;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        idle();

        check("rst_busc", busc, 8'h00);
        read_reg(3'b100, 8'h00, "rst_fix0");
        read_reg(3'b101, 8'h01, "rst_fix1");
        read_reg(3'b000, 8'h00, "rst_gen0");
        read_reg(3'b011, 8'h00, "rst_gen3");

        // Reset mid-ABS with conflicting controls active on the same edge.
        abs_seq(1'b1);
        read_reg(3'b011, 8'h09, "mid_gen3_before");
        rst_n      = 1'b0;
        dec_sel    = 3'b011;
        sel_a      = 3'b100;
        alu_op     = 4'b0011;
        load_n     = 1'b0;
        fix_load_n = 1'b0;
        fix0_in    = 8'hAA;
        fix1_in    = 8'hBB;
`ifdef SC_DATAPATH_DEBUG_READ_EN
        dbg_sel    = 3'b011;
`endif
        tick();
        idle();
        check("mid_rst_busc", busc, 8'h00);
`ifdef SC_DATAPATH_DEBUG_READ_EN
        check("mid_rst_debug", dbg_out, 8'h00);
`endif
        sel_a = 3'b011;
        #1;
        check("mid_rst_gen3_zero", {7'd0, z_n}, 8'h00);
        sel_a = 3'b100;
        #1;
        check("mid_rst_fix0_zero", {7'd0, z_n}, 8'h00);
        read_reg(3'b101, 8'h01, "mid_rst_fix1");

        abs_seq(1'b0);

        for (int i = 0; i < 17; i++) begin
            load_fix(vecs[i].a, vecs[i].b);
            sel_a  = 3'b100;
            sel_b  = 3'b101;
            alu_op = vecs[i].op;
            load_n = 1'b0;
            #1;
            check($sformatf("vec%0d_flags", i), flags(), {4'b0000, vecs[i].flg});
            tick();
            idle();
            check($sformatf("vec%0d_result", i), busc, vecs[i].res);
        end

        // Muxes on codes 110/111 supply zero.
        load_fix(8'h55, 8'h66);
        sel_a  = 3'b100;
        sel_b  = 3'b111;
        alu_op = 4'b1000;
        #1;
        check("busb_111_add", flags(), 8'h0F);
        sel_a  = 3'b110;
        alu_op = 4'b0000;
        #1;
        check("busa_110_zero", {7'd0, z_n}, 8'h00);

        // Shifter sequence.
        load_fix(8'h81, 8'h3C);
        read_reg(3'b100, 8'h81, "sh_load");
        shift_sel = 2'b01;
        tick();
        check("sh_left", busc, 8'h02);
        shift_sel = 2'b10;
        tick();
        check("sh_right1", busc, 8'h01);
        tick();
        check("sh_right2", busc, 8'h00);
        shift_sel = 2'b11;
        tick();
        check("sh_hold", busc, 8'h00);
        idle();
        sel_a     = 3'b100;
        load_n    = 1'b0;
        shift_sel = 2'b01;
        tick();
        idle();
        check("sh_load_wins", busc, 8'h81);

        // GEN1 write on the same edge as a shifter load keeps the old BUSC.
        dec_sel = 3'b001;
        sel_a   = 3'b101;
        load_n  = 1'b0;
        tick();
        idle();
        check("wr_ld_busc", busc, 8'h3C);
        read_reg(3'b001, 8'h81, "wr_ld_gen1");

        read_reg(3'b101, 8'h3C, "wr111_busc");
        dec_sel = 3'b111;
        tick();
        idle();
        read_reg(3'b000, 8'h00, "wr111_gen0");
        read_reg(3'b001, 8'h81, "wr111_gen1");
        read_reg(3'b010, 8'h00, "wr111_gen2");
        read_reg(3'b011, 8'h0A, "wr111_gen3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
